// File: rtl/sequenciador_medidas.sv
// Periodic distance-measurement sequencer.
// Requests a sample from the sensor interface, waits for it with a timeout,
// converts the 3-digit BCD reading to binary and accumulates it. Every 4 valid
// samples it publishes their truncated average and a proximity alert.
// A timeout or a malformed BCD reading discards the whole 4-sample window and
// raises the sticky falha flag, which stays set until the next good average.
//
// Handshake with the sensor interface: medir is a single-cycle request issued
// from PEDE; pronto is only honoured while waiting in ESPERA and is ignored in
// every other state, so late or spurious completions cannot corrupt the window.
module sequenciador_medidas #(
  parameter int INTERVALO = 3000000,
  parameter int TIMEOUT   = 2500000,
  parameter int LIMIAR    = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic [11:0] medida,
  input  logic        pronto,
  output logic        medir,
  output logic [9:0]  media,
  output logic        media_valida,
  output logic        alerta,
  output logic        falha,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    EST_OCIOSO    = 4'd0,
    EST_PEDE      = 4'd1,
    EST_ESPERA    = 4'd2,
    EST_ACUMULA   = 4'd3,
    EST_CALCULA   = 4'd4,
    EST_INTERVALO = 4'd5,
    EST_FALHA     = 4'd6
  } estado_t;

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int INT_W = (INTERVALO > 1) ? $clog2(INTERVALO + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_FIM = TMO_W'(TIMEOUT - 1);
  localparam logic [INT_W-1:0] INT_FIM = INT_W'(INTERVALO - 1);
  localparam logic [9:0]       LIMIAR_B = 10'(LIMIAR);

  estado_t           estado, estado_prox;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [INT_W-1:0]  int_cnt;
  logic [11:0]       captura;
  logic              captura_ok;
  logic [11:0]       soma;
  logic [1:0]        n_amostras;
  logic [11:0]       valor;
  logic              digitos_ok;
  logic [9:0]        media_nova;

  // Binary value of the captured BCD reading and digit-range check of the input.
  always_comb begin
    valor      = 12'(captura[11:8]) * 12'd100
               + 12'(captura[7:4])  * 12'd10
               + 12'(captura[3:0]);
    digitos_ok = (medida[11:8] <= 4'd9) && (medida[7:4] <= 4'd9) &&
                 (medida[3:0] <= 4'd9);
    media_nova = soma[11:2];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= EST_OCIOSO;
    else       estado <= estado_prox;
  end

  // Next-state logic; medir is a Moore output of PEDE.
  always_comb begin
    estado_prox = estado;
    medir       = 1'b0;
    case (estado)
      EST_OCIOSO:    if (ligar) estado_prox = EST_PEDE;
      EST_PEDE: begin
        medir       = 1'b1;
        estado_prox = EST_ESPERA;
      end
      EST_ESPERA: begin
        // A completion arriving on the last timeout cycle still counts.
        if (pronto)                  estado_prox = EST_ACUMULA;
        else if (tmo_cnt == TMO_FIM) estado_prox = EST_FALHA;
      end
      EST_ACUMULA: begin
        if (!captura_ok)               estado_prox = EST_FALHA;
        else if (n_amostras == 2'd3)   estado_prox = EST_CALCULA;
        else                           estado_prox = EST_INTERVALO;
      end
      EST_CALCULA:   estado_prox = EST_INTERVALO;
      EST_INTERVALO: if (int_cnt == INT_FIM) estado_prox = ligar ? EST_PEDE : EST_OCIOSO;
      EST_FALHA:     estado_prox = EST_INTERVALO;
      default:       estado_prox = EST_OCIOSO;
    endcase
  end

  assign db_estado = estado;

  // Timeout counter: cleared when the request goes out, advances while waiting.
  always_ff @(posedge clock) begin
    if (reset || estado == EST_PEDE)
      tmo_cnt <= '0;
    else if (estado == EST_ESPERA && !pronto && tmo_cnt != TMO_FIM)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Interval counter: held at zero outside INTERVALO so every entry starts fresh.
  always_ff @(posedge clock) begin
    if (reset || estado != EST_INTERVALO)
      int_cnt <= '0;
    else if (int_cnt != INT_FIM)
      int_cnt <= int_cnt + 1'b1;
  end

  // Capture the reading on the cycle the sensor reports completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      captura    <= '0;
      captura_ok <= 1'b0;
    end else if (estado == EST_ESPERA && pronto) begin
      captura    <= medida;
      captura_ok <= digitos_ok;
    end
  end

  // Window accumulator: add good samples, drop everything on failure/publish/idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      soma       <= '0;
      n_amostras <= '0;
    end else if (estado == EST_ACUMULA && captura_ok) begin
      soma       <= soma + valor;
      n_amostras <= n_amostras + 1'b1;
    end else if (estado == EST_FALHA || estado == EST_CALCULA ||
                 (estado_prox == EST_OCIOSO && estado != EST_OCIOSO)) begin
      soma       <= '0;
      n_amostras <= '0;
    end
  end

  // Registered results: updated on the edge that leaves CALCULA, held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      media        <= '0;
      media_valida <= 1'b0;
      alerta       <= 1'b0;
      falha        <= 1'b0;
    end else begin
      media_valida <= (estado == EST_CALCULA);
      if (estado == EST_CALCULA) begin
        media  <= media_nova;
        alerta <= (media_nova < LIMIAR_B);
        falha  <= 1'b0;
      end else if (estado == EST_FALHA) begin
        falha  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_medidas.sv
// Directed bench for sequenciador_medidas with short interval/timeout values.
module tb_sequenciador_medidas;

  localparam int P_INTERVALO = 10;
  localparam int P_TIMEOUT   = 20;
  localparam int P_LIMIAR    = 20;

  logic        clock;
  logic        reset;
  logic        ligar;
  logic [11:0] medida;
  logic        pronto;
  logic        medir;
  logic [9:0]  media;
  logic        media_valida;
  logic        alerta;
  logic        falha;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  sequenciador_medidas #(
    .INTERVALO(P_INTERVALO),
    .TIMEOUT  (P_TIMEOUT),
    .LIMIAR   (P_LIMIAR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ligar       (ligar),
    .medida      (medida),
    .pronto      (pronto),
    .medir       (medir),
    .media       (media),
    .media_valida(media_valida),
    .alerta      (alerta),
    .falha       (falha),
    .db_estado   (db_estado)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  // medir monitor on the falling edge: pulse count, minimum spacing, width.
  int cyc       = 0;
  int n_medir   = 0;
  int ult_medir = 0;
  int min_gap   = 1000000;
  int n_dupla   = 0;
  logic medir_ant = 1'b0;

  always begin
    @(negedge clock);
    cyc++;
    if (medir === 1'b1) begin
      if (medir_ant) n_dupla++;
      if (n_medir > 0 && (cyc - ult_medir) < min_gap) min_gap = cyc - ult_medir;
      ult_medir = cyc;
      n_medir++;
    end
    medir_ant = (medir === 1'b1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  task automatic wait_medir();
    bit visto;
    visto = 1'b0;
    for (int i = 0; i < 200 && !visto; i++) begin
      tick();
      if (medir === 1'b1) visto = 1'b1;
    end
    if (!visto) check("medir_timeout", 0, 1);
  endtask

  // Wait for a request, stay atraso cycles in ESPERA, then return a reading.
  task automatic send_sample(input logic [11:0] val, input int atraso);
    wait_medir();
    tick();
    repeat (atraso) tick();
    check("em_espera", 32'(db_estado), 2);
    medida = val;
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    medida = 12'h000;
  endtask

  // Follow ACUMULA and the next two cycles; media_valida only on the 4th sample.
  task automatic finish_sample(input bit ultima, input logic [9:0] em, input logic ea);
    check("acumula", 32'(db_estado), 3);
    check("mv_acumula", 32'(media_valida), 0);
    tick();
    check("pos_acumula", 32'(db_estado), ultima ? 4 : 5);
    tick();
    check("mv_pulso", 32'(media_valida), 32'(ultima));
    if (ultima) begin
      check("media", 32'(media), 32'(em));
      check("alerta", 32'(alerta), 32'(ea));
      check("falha_limpa", 32'(falha), 0);
    end
    tick();
    check("mv_fim", 32'(media_valida), 0);
  endtask

  typedef struct packed {
    logic [3:0][11:0] s;
    logic [4:0]       atraso;
    logic [9:0]       exp_media;
    logic             exp_alerta;
  } janela_t;

  janela_t tab[6];

  initial begin
    int base;
    int n;

    tab[0] = '{s: {12'h024, 12'h020, 12'h016, 12'h012}, atraso: 5'd0, exp_media: 10'd18,  exp_alerta: 1'b1};
    tab[1] = '{s: {12'h103, 12'h100, 12'h100, 12'h100}, atraso: 5'd2, exp_media: 10'd100, exp_alerta: 1'b0};
    tab[2] = '{s: {12'h999, 12'h999, 12'h999, 12'h999}, atraso: 5'd1, exp_media: 10'd999, exp_alerta: 1'b0};
    tab[3] = '{s: {12'h021, 12'h020, 12'h020, 12'h019}, atraso: 5'd3, exp_media: 10'd20,  exp_alerta: 1'b0};
    tab[4] = '{s: {12'h019, 12'h020, 12'h019, 12'h019}, atraso: 5'd19, exp_media: 10'd19, exp_alerta: 1'b1};
    tab[5] = '{s: {12'h003, 12'h000, 12'h000, 12'h000}, atraso: 5'd0, exp_media: 10'd0,   exp_alerta: 1'b1};

    reset  = 1'b1;
    ligar  = 1'b0;
    pronto = 1'b0;
    medida = 12'h000;
    repeat (3) tick();
    check("rst_medir", 32'(medir), 0);
    check("rst_media", 32'(media), 0);
    check("rst_mv", 32'(media_valida), 0);
    check("rst_alerta", 32'(alerta), 0);
    check("rst_falha", 32'(falha), 0);
    check("rst_estado", 32'(db_estado), 0);
    reset = 1'b0;
    repeat (20) tick();
    check("ocioso_sem_medir", n_medir, 0);
    check("ocioso_estado", 32'(db_estado), 0);

    // Table of complete 4-sample windows.
    ligar = 1'b1;
    for (int w = 0; w < 6; w++) begin
      base = n_medir;
      if (w > 0) check("media_mantida", 32'(media), 32'(tab[w-1].exp_media));
      for (int j = 0; j < 4; j++) begin
        send_sample(tab[w].s[j], int'(tab[w].atraso));
        finish_sample(j == 3, tab[w].exp_media, tab[w].exp_alerta);
      end
      check("medir_por_janela", n_medir - base, 4);
    end

    // Timeout on the second request discards the window.
    send_sample(12'h040, 1);
    finish_sample(1'b0, 10'd0, 1'b0);
    wait_medir();
    tick();
    n = 0;
    while (db_estado == 4'd2 && n < 50) begin
      n++;
      tick();
    end
    check("ciclos_espera", n, P_TIMEOUT);
    check("estado_falha", 32'(db_estado), 6);
    tick();
    check("falha_timeout", 32'(falha), 1);
    check("pos_falha", 32'(db_estado), 5);
    for (int j = 0; j < 4; j++) begin
      send_sample(12'h040, 0);
      finish_sample(j == 3, 10'd40, 1'b0);
      if (j < 3) check("falha_retida", 32'(falha), 1);
    end

    // Malformed BCD reading discards the window; stray pronto in INTERVALO ignored.
    send_sample(12'h010, 0);
    finish_sample(1'b0, 10'd0, 1'b0);
    send_sample(12'h010, 0);
    finish_sample(1'b0, 10'd0, 1'b0);
    send_sample(12'h0A5, 0);
    check("bcd_acumula", 32'(db_estado), 3);
    tick();
    check("bcd_falha", 32'(db_estado), 6);
    tick();
    check("bcd_falha_flag", 32'(falha), 1);
    tick();
    medida = 12'h999;
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    medida = 12'h000;
    for (int j = 0; j < 4; j++) begin
      send_sample(12'h015, 0);
      finish_sample(j == 3, 10'd15, 1'b1);
    end
    send_sample(12'h0A5, 1);
    tick();
    tick();
    check("falha_antes_reset", 32'(falha), 1);

    // Reset while waiting in ESPERA, followed by a late completion.
    wait_medir();
    tick();
    check("espera_antes_reset", 32'(db_estado), 2);
    reset = 1'b1;
    ligar = 1'b0;
    tick();
    reset = 1'b0;
    check("r2_medir", 32'(medir), 0);
    check("r2_media", 32'(media), 0);
    check("r2_mv", 32'(media_valida), 0);
    check("r2_alerta", 32'(alerta), 0);
    check("r2_falha", 32'(falha), 0);
    check("r2_estado", 32'(db_estado), 0);
    base = n_medir;
    tick();
    medida = 12'h050;
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    repeat (30) tick();
    check("pronto_tardio_estado", 32'(db_estado), 0);
    check("pronto_tardio_medir", n_medir - base, 0);
    check("pronto_tardio_media", 32'(media), 0);

    // ligar dropped while waiting: sample finishes, interval runs, then idle.
    ligar = 1'b1;
    wait_medir();
    tick();
    check("desliga_espera", 32'(db_estado), 2);
    ligar = 1'b0;
    tick();
    medida = 12'h050;
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    check("desliga_acumula", 32'(db_estado), 3);
    tick();
    n = 0;
    while (db_estado == 4'd5 && n < 50) begin
      n++;
      tick();
    end
    check("ciclos_intervalo", n, P_INTERVALO);
    check("desliga_ocioso", 32'(db_estado), 0);
    repeat (40) tick();
    check("desliga_sem_medir", n_medir - base, 1);

    // The partial sample above must have been discarded on entry to idle.
    ligar = 1'b1;
    for (int j = 0; j < 4; j++) begin
      send_sample(12'h080, 0);
      finish_sample(j == 3, 10'd80, 1'b0);
    end
    ligar = 1'b0;
    repeat (20) tick();

    check("min_espaco_medir", min_gap, 13);
    check("medir_largura", n_dupla, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_medidas.md
SEQUENCIADOR_MEDIDAS -- requirements
Module: sequenciador_medidas

Interface
REQ-001 SHALL have parameter INTERVALO, default 3000000, meaning idle cycles between measurements (60 ms at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 2500000, meaning maximum cycles to wait for pronto after medir.
REQ-003 SHALL have parameter LIMIAR, default 20, meaning proximity threshold in cm (binary).
REQ-004 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ligar  input  1  level: enables continuous periodic measurement.
REQ-007 SHALL have port medida  input  12  distance from sensor interface, 3 BCD digits (cm), [11:8] hundreds.
REQ-008 SHALL have port pronto  input  1  sensor interface measurement-complete pulse.
REQ-009 SHALL have port medir  output  1  one-cycle start pulse to sensor interface.
REQ-010 SHALL have port media  output  10  binary average of last 4 valid samples, cm.
REQ-011 SHALL have port media_valida  output  1  one-cycle pulse when media updates.
REQ-012 SHALL have port alerta  output  1  registered: last media < LIMIAR.
REQ-013 SHALL have port falha  output  1  sticky sample-failure flag.
REQ-014 SHALL have port db_estado  output  4  current FSM state code.

Function
REQ-015 SHALL implement FSM states OCIOSO=0, PEDE=1, ESPERA=2, ACUMULA=3, CALCULA=4, INTERVALO=5, FALHA=6; unused codes go to OCIOSO next cycle.
REQ-016 SHALL, in OCIOSO, move to PEDE when ligar=1, else stay.
REQ-017 SHALL assert medir for exactly the one cycle spent in PEDE, clear the timeout counter, then go to ESPERA.
REQ-018 SHALL, in ESPERA, go to ACUMULA when pronto=1; else increment timeout counter and go to FALHA when counter reaches TIMEOUT-1.
REQ-019 SHALL give pronto priority over timeout when both occur in the same cycle.
REQ-020 SHALL ignore pronto in every state other than ESPERA.
REQ-021 SHALL capture medida on the ESPERA cycle where pronto=1; capture is valid only if every BCD digit is 0-9.
REQ-022 SHALL, in ACUMULA with valid capture, add hundreds*100+tens*10+units to a 12-bit sum (max 3996, no overflow) and increment a 2-bit sample count; go to CALCULA if this was sample 4, else INTERVALO.
REQ-023 SHALL, in ACUMULA with invalid capture, behave as FALHA (sum and count unchanged by sample).
REQ-024 SHALL, in FALHA, set falha=1, clear sum and sample count (whole window discarded), go to INTERVALO.
REQ-025 SHALL, in CALCULA, load media=sum>>2 (truncating), alerta=(sum>>2)<LIMIAR, pulse media_valida, clear falha, clear sum and count, go to INTERVALO.
REQ-026 SHALL register media, media_valida, alerta so they change on the edge leaving CALCULA: pronto of 4th sample at edge k -> media_valida high in cycle k+3 only.
REQ-027 SHALL hold media and alerta between updates.
REQ-028 SHALL, in INTERVALO, count INTERVALO cycles from entry, then go to PEDE if ligar=1, else OCIOSO.
REQ-029 SHALL, when ligar falls mid-sequence, finish current state path and enter OCIOSO at end of INTERVALO; sum and count cleared on entry to OCIOSO.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, from any state: state OCIOSO, medir=0, media=0, media_valida=0, alerta=0, falha=0, db_estado=0, sum, count and both counters cleared.
REQ-031 SHALL issue no medir until ligar=1 after reset is released.

Verification (INTERVALO=10, TIMEOUT=20, LIMIAR=20)
REQ-032 SHALL pass: ligar=1, pronto with medida 0x012,0x016,0x020,0x024 -> one media_valida pulse, media=18, alerta=1, exactly 4 medir pulses 3+10 cycles minimum apart.
REQ-033 SHALL pass: samples 0x100,0x100,0x100,0x103 -> media=100, alerta=0, falha=0.
REQ-034 SHALL pass: no pronto after 2nd medir -> db_estado=6 after 20 ESPERA cycles, falha=1; next 4 samples 0x040 -> media=40, falha cleared on media_valida.
REQ-035 SHALL pass: pronto with medida 0x0A5 -> treated as failure, falha=1, no accumulation.
REQ-036 SHALL pass: reset asserted in ESPERA -> next cycle all outputs 0, db_estado=0; late pronto ignored.
REQ-037 SHALL pass: ligar dropped during ESPERA -> sample completes, after INTERVALO db_estado=0, no further medir.
